// File: rtl/retry_inorder_end_pkg.sv
// Shared constants and helpers for the in-order retry terminator and its slot store.
package retry_inorder_end_pkg;

  localparam int unsigned DefaultIdSize = 4;

  function automatic int unsigned slot_count(input int unsigned id_size);
    return 32'd1 << id_size;
  endfunction

endpackage

// File: rtl/retry_inorder_slots.sv
// Slot store indexed by ID: one write port, one read/clear port, full flag per entry.
module retry_inorder_slots
  import retry_inorder_end_pkg::*;
#(
  parameter type         DataType = logic,
  parameter int unsigned IDSize   = DefaultIdSize
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDSize-1:0] wr_id,
  input  DataType           wr_data,
  input  logic [IDSize-1:0] rd_id,
  input  logic              clr_en,
  output logic              rd_full,
  output DataType           rd_data,
  output logic              wr_full
);

  localparam int unsigned Slots = slot_count(IDSize);

  logic [Slots-1:0] full;
  DataType          mem [Slots];

  // Full flags are control state; payload storage is never reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
    end else begin
      if (clr_en) full[rd_id] <= 1'b0;
      if (wr_en)  full[wr_id] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_id] <= wr_data;
  end

  assign rd_full = full[rd_id];
  assign rd_data = mem[rd_id];
  assign wr_full = full[wr_id];

endmodule

// File: rtl/retry_inorder_end.sv
// Retry-loop terminator: bounces failed IDs back upstream and releases good items in ID order.
module retry_inorder_end
  import retry_inorder_end_pkg::*;
#(
  parameter type         DataType = logic,
  parameter int unsigned IDSize   = DefaultIdSize
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  DataType           data_i,
  input  logic [IDSize-1:0] id_i,
  input  logic              needs_retry_i,
  input  logic              valid_i,
  output logic              ready_o,
  output DataType           data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [IDSize-1:0] retry_id_o,
  output logic              retry_valid_o,
  input  logic              retry_ready_i,
  output logic [IDSize:0]   occupancy_o,
  output logic              drop_o
);

  localparam logic [IDSize-1:0] IdOne  = 1;
  localparam logic [IDSize:0]   OccOne = 1;

  logic [IDSize-1:0] expected_id;
  logic              retry_q_valid;
  logic [IDSize-1:0] retry_q_id;
  logic [IDSize:0]   occupancy;
  logic              drop;

  logic    slot_full_rd;
  logic    slot_full_wr;
  DataType slot_data;
  logic    good_in;
  logic    wr_en;
  logic    pop;
  logic    retry_load;

  assign good_in    = valid_i & ~needs_retry_i;
  assign wr_en      = good_in & ~slot_full_wr;
  assign pop        = slot_full_rd & ready_i;
  // Good items are always accepted; duplicates are swallowed rather than stalling upstream.
  assign ready_o    = needs_retry_i ? (~retry_q_valid | retry_ready_i) : 1'b1;
  assign retry_load = valid_i & needs_retry_i & ready_o;

  retry_inorder_slots #(
    .DataType(DataType),
    .IDSize  (IDSize)
  ) u_slots (
    .clk    (clk_i),
    .rst    (rst_i),
    .wr_en  (wr_en),
    .wr_id  (id_i),
    .wr_data(data_i),
    .rd_id  (expected_id),
    .clr_en (pop),
    .rd_full(slot_full_rd),
    .rd_data(slot_data),
    .wr_full(slot_full_wr)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      expected_id   <= '0;
      retry_q_valid <= 1'b0;
      retry_q_id    <= '0;
      occupancy     <= '0;
      drop          <= 1'b0;
    end else begin
      if (pop) expected_id <= expected_id + IdOne;

      // A load in the same cycle as a drain replaces the entry without a bubble.
      if (retry_load) begin
        retry_q_valid <= 1'b1;
        retry_q_id    <= id_i;
      end else if (retry_ready_i) begin
        retry_q_valid <= 1'b0;
      end

      case ({wr_en, pop})
        2'b10:   occupancy <= occupancy + OccOne;
        2'b01:   occupancy <= occupancy - OccOne;
        default: occupancy <= occupancy;
      endcase

      drop <= good_in & slot_full_wr;
    end
  end

  assign valid_o       = slot_full_rd;
  assign data_o        = slot_full_rd ? slot_data : '0;
  assign retry_valid_o = retry_q_valid;
  assign retry_id_o    = retry_q_id;
  assign occupancy_o   = occupancy;
  assign drop_o        = drop;

endmodule

// File: tb/tb_retry_inorder_end.sv
// Directed bench for retry_inorder_end with a slot-level reference model checked every cycle.
module tb_retry_inorder_end;

  logic        clk;
  logic        rst_i;
  logic [15:0] data_i;
  logic [1:0]  id_i;
  logic        needs_retry_i;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic [1:0]  retry_id_o;
  logic        retry_valid_o;
  logic        retry_ready_i;
  logic [2:0]  occupancy_o;
  logic        drop_o;

  int checks   = 0;
  int failures = 0;

  retry_inorder_end #(
    .DataType(logic [15:0]),
    .IDSize  (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .data_i       (data_i),
    .id_i         (id_i),
    .needs_retry_i(needs_retry_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .retry_id_o   (retry_id_o),
    .retry_valid_o(retry_valid_o),
    .retry_ready_i(retry_ready_i),
    .occupancy_o  (occupancy_o),
    .drop_o       (drop_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a table of parked items plus the next ID owed downstream.
  bit          mv [4];
  logic [15:0] md [4];
  int          mexp;
  bit          mrv;
  int          mrid;
  bit          mdrop;
  bit          model_ok = 1'b0;

  function automatic int filled();
    int n = 0;
    for (int k = 0; k < 4; k++) n += int'(mv[k]);
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst_i) begin
      for (int k = 0; k < 4; k++) mv[k] = 1'b0;
      mexp = 0; mrv = 1'b0; mrid = 0; mdrop = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      bit hit;
      bit rel;
      hit   = mv[id_i];
      rel   = mv[mexp] && ready_i;
      mdrop = 1'b0;
      if (valid_i && needs_retry_i) begin
        if (!mrv || retry_ready_i) begin
          mrv  = 1'b1;
          mrid = int'(id_i);
        end
      end else if (retry_ready_i) begin
        mrv = 1'b0;
      end
      if (valid_i && !needs_retry_i) begin
        if (hit) mdrop = 1'b1;
        else begin
          mv[id_i] = 1'b1;
          md[id_i] = data_i;
        end
      end
      if (rel) begin
        mv[mexp] = 1'b0;
        mexp     = (mexp + 1) % 4;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok && !rst_i) begin
      chk("m_valid", 32'(valid_o), 32'(mv[mexp]));
      if (mv[mexp]) chk("m_data", 32'(data_o), 32'(md[mexp]));
      chk("m_occ", 32'(occupancy_o), 32'(filled()));
      chk("m_rvalid", 32'(retry_valid_o), 32'(mrv));
      if (mrv) chk("m_rid", 32'(retry_id_o), 32'(mrid));
      chk("m_drop", 32'(drop_o), 32'(mdrop));
      chk("m_ready", 32'(ready_o), needs_retry_i ? 32'(!mrv || retry_ready_i) : 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] id, input logic [15:0] d, input logic retry);
    valid_i       = 1'b1;
    id_i          = id;
    data_i        = d;
    needs_retry_i = retry;
  endtask

  task automatic do_reset();
    rst_i   = 1'b1;
    valid_i = 1'b0;
    cyc();
    rst_i = 1'b0;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_occ", 32'(occupancy_o), 32'd0);
    chk("rst_rvalid", 32'(retry_valid_o), 32'd0);
    chk("rst_drop", 32'(drop_o), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; id_i = '0; data_i = '0; needs_retry_i = 1'b0;
    ready_i = 1'b1; retry_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    chk("init_valid", 32'(valid_o), 32'd0);
    chk("init_data", 32'(data_o), 32'd0);
    chk("init_rid", 32'(retry_id_o), 32'd0);
    chk("init_occ", 32'(occupancy_o), 32'd0);

    // 1: in-order stream with ID wrap
    for (int i = 0; i < 5; i++) begin
      drive(2'(i % 4), 16'hA000 + 16'(i), 1'b0);
      cyc();
      chk("s1_valid", 32'(valid_o), 32'd1);
      chk("s1_data", 32'(data_o), 32'hA000 + 32'(i));
    end
    valid_i = 1'b0;
    cyc();
    chk("s1_idle", 32'(valid_o), 32'd0);

    // 2: retry of id1 holds back id2/id3
    do_reset();
    drive(2'd0, 16'hA000, 1'b0); cyc();
    chk("s2_d0", 32'(data_o), 32'hA000);
    drive(2'd1, 16'hA001, 1'b1); cyc();
    chk("s2_rvalid", 32'(retry_valid_o), 32'd1);
    chk("s2_rid", 32'(retry_id_o), 32'd1);
    chk("s2_hold", 32'(valid_o), 32'd0);
    drive(2'd2, 16'hA002, 1'b0); cyc();
    drive(2'd3, 16'hA003, 1'b0); cyc();
    chk("s2_hold2", 32'(valid_o), 32'd0);
    drive(2'd1, 16'hA001, 1'b0); cyc();
    chk("s2_d1", 32'(data_o), 32'hA001);
    valid_i = 1'b0; cyc();
    chk("s2_d2", 32'(data_o), 32'hA002);
    cyc();
    chk("s2_d3", 32'(data_o), 32'hA003);
    cyc();
    chk("s2_end", 32'(valid_o), 32'd0);

    // 3: retry register backpressure
    retry_ready_i = 1'b0;
    do_reset();
    drive(2'd1, 16'h0, 1'b1); #1;
    chk("s3_rdy1", 32'(ready_o), 32'd1);
    cyc();
    chk("s3_rid1", 32'(retry_id_o), 32'd1);
    drive(2'd2, 16'h0, 1'b1); #1;
    chk("s3_rdy0", 32'(ready_o), 32'd0);
    cyc();
    chk("s3_rid_hold", 32'(retry_id_o), 32'd1);
    retry_ready_i = 1'b1; #1;
    chk("s3_rdy_up", 32'(ready_o), 32'd1);
    cyc();
    chk("s3_rvalid2", 32'(retry_valid_o), 32'd1);
    chk("s3_rid2", 32'(retry_id_o), 32'd2);
    valid_i = 1'b0; cyc();
    chk("s3_rdrain", 32'(retry_valid_o), 32'd0);

    // 4: duplicate into a full slot is dropped
    do_reset();
    drive(2'd2, 16'hB002, 1'b0); cyc();
    chk("s4_occ1", 32'(occupancy_o), 32'd1);
    drive(2'd2, 16'hDEAD, 1'b0); cyc();
    chk("s4_drop", 32'(drop_o), 32'd1);
    chk("s4_occ", 32'(occupancy_o), 32'd1);
    drive(2'd0, 16'hC000, 1'b0); cyc();
    chk("s4_nodrop", 32'(drop_o), 32'd0);
    chk("s4_d0", 32'(data_o), 32'hC000);
    drive(2'd1, 16'hC001, 1'b0); cyc();
    chk("s4_d1", 32'(data_o), 32'hC001);
    valid_i = 1'b0; cyc();
    chk("s4_d2", 32'(data_o), 32'hB002);
    cyc();

    // 5: fill all slots under downstream backpressure
    ready_i = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(2'(i), 16'hD000 + 16'(i), 1'b0); #1;
      chk("s5_rdy", 32'(ready_o), 32'd1);
      cyc();
    end
    valid_i = 1'b0;
    chk("s5_occ4", 32'(occupancy_o), 32'd4);
    ready_i = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      chk("s5_data", 32'(data_o), 32'hD000 + 32'(i));
      cyc();
    end
    chk("s5_occ0", 32'(occupancy_o), 32'd0);
    chk("s5_empty", 32'(valid_o), 32'd0);

    // 6: reset while busy
    ready_i = 1'b0; retry_ready_i = 1'b0;
    do_reset();
    drive(2'd1, 16'hE001, 1'b0); cyc();
    drive(2'd3, 16'hE003, 1'b0); cyc();
    drive(2'd0, 16'h0, 1'b1); cyc();
    chk("s6_rv_pre", 32'(retry_valid_o), 32'd1);
    chk("s6_occ_pre", 32'(occupancy_o), 32'd2);
    do_reset();
    chk("s6_rid0", 32'(retry_id_o), 32'd0);
    ready_i = 1'b1;
    drive(2'd0, 16'h1234, 1'b0); cyc();
    chk("s6_valid", 32'(valid_o), 32'd1);
    chk("s6_data", 32'(data_o), 32'h1234);
    valid_i = 1'b0; cyc();
    chk("s6_end", 32'(valid_o), 32'd0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/retry_inorder_end.md
Name: retry_inorder_end

Overview:
- Terminating stage of the time-redundant retry loop; sits directly downstream of time_DMR_end and feeds retry_start's retry port.
- Items flagged needs_retry go back as retry IDs.
- Good items are parked in slots indexed by ID and released downstream strictly in ID-issue order. Retried items therefore never overtake or reorder the output stream.

Parameters:
DataType, logic, payload type carried through unchanged
IDSize, 4, ID width; slot count = 2**IDSize; retry_start must keep at most 2**IDSize IDs outstanding

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
data_i  in  $bits(DataType)  payload from time_DMR_end
id_i  in  IDSize  ID of the payload
needs_retry_i  in  1  payload failed the DMR check
valid_i  in  1  upstream valid
ready_o  out  1  upstream ready
data_o  out  $bits(DataType)  in-order payload
valid_o  out  1  downstream valid
ready_i  in  1  downstream ready
retry_id_o  out  IDSize  ID to reissue
retry_valid_o  out  1  retry valid
retry_ready_i  in  1  retry ready from retry_start
occupancy_o  out  IDSize+1  number of filled slots
drop_o  out  1  one-cycle pulse: good item discarded as duplicate

Behaviour:
- Reset (rst_i high at a posedge) sets the following, regardless of any handshake in that cycle:
  - all slot valid bits = 0
  - expected_id = 0
  - retry register empty
  - occupancy_o = 0; drop_o = 0; valid_o = 0; retry_valid_o = 0
  - data_o and retry_id_o are don't-care but held at 0
- Upstream must be reset in the same cycle.
- State:
  - slot array: 2**IDSize entries, each a valid bit plus data
  - expected_id counter: IDSize bits, wraps modulo 2**IDSize
  - one-entry retry register: valid plus ID
- Input with needs_retry_i = 1:
  - ready_o = !retry_q_valid | retry_ready_i
  - on handshake, retry register loads id_i
  - retry_valid_o/retry_id_o driven from the register; latency 1 cycle
  - data is discarded; slots are untouched
- Input with needs_retry_i = 0:
  - ready_o = 1 always
  - slot[id_i] empty: write data, set valid
  - slot[id_i] full: accept and discard, drop_o pulses the next cycle, slot contents unchanged (covers duplicates from fault-induced replays)
- Output:
  - valid_o = slot_valid[expected_id]; data_o = slot_data[expected_id]; both purely from registers
  - minimum input-to-output latency 1 cycle
  - on valid_o & ready_i: clear that slot, expected_id += 1
- Simultaneous events:
  - write to slot X while slot expected_id is released, X != expected_id: both happen
  - X == expected_id while it is valid: drop rule applies
  - X == expected_id while it is empty: written, visible next cycle
  - retry register drain and load in the same cycle: new ID wins, no bubble
- Occupancy:
  - += 1 on slot write; -= 1 on release; unchanged when both happen in one cycle
  - drops do not count
  - max value 2**IDSize
- No timeout. A permanently missing ID stalls output by design; its recovery is owned by the retry loop.

Decomposition:
- No new package types; DataType and IDSize stay parametric.
- One sub-module, retry_inorder_slots: slot storage plus valid bits.
  - one write port, one read/clear port
  - full flag per entry
- Top level holds expected_id, the retry register, occupancy and handshake logic.

Test Plan:
All scenarios use IDSize=2 and DataType = logic[15:0].
1. In-order: ids 0,1,2,3,0 with data 0xA000..0xA004 on consecutive cycles, ready_i=1 -> same five values on data_o, each exactly 1 cycle after its input; expected_id wraps 3->0.
2. Retry: id0 good, id1 needs_retry, id2 good, id3 good -> retry_valid_o=1 with retry_id_o=1 one cycle later; only 0xA000 is output. Re-present id1=0xA001 good -> 0xA001, 0xA002, 0xA003 on three consecutive cycles.
3. Retry backpressure: retry_ready_i=0, two needs_retry items (ids 1, 2) -> first accepted, second sees ready_o=0. Raise retry_ready_i -> retry_id_o=1 then 2 on successive cycles.
4. Duplicate: slot 2 holds 0xB002 and expected_id=0; id2=0xDEAD arrives good -> accepted, drop_o=1 next cycle, occupancy_o stays 1, later output of id 2 is 0xB002.
5. Full/backpressure: ready_i=0, ids 0..3 written -> occupancy_o=4, ready_o stays 1. Raise ready_i -> four outputs in four cycles, then occupancy_o=0 and valid_o=0.
6. Reset mid-op: slots 1,3 full, retry register valid, assert rst_i for one cycle -> next cycle valid_o=0, retry_valid_o=0, occupancy_o=0, expected_id=0. A following id0=0x1234 good is output 1 cycle later.
